handshake_mux: RTL and testbench
================================

HANDSHAKE_MUX -- requirements
Module: handshake_mux

Interface
REQ-001 Parameter WIDTH, default 32, width of each data input and of the output data.
REQ-002 Parameter NUM_INPUTS, default 2, number of data inputs; legal range 2..16.
REQ-003 Derived constant SEL_WIDTH = $clog2(NUM_INPUTS), width of the select token.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sel_valid  input  1  select token valid.
REQ-007 sel_ready  output  1  select token consumed this cycle.
REQ-008 sel_data  input  SEL_WIDTH  index of the data input to forward.
REQ-009 in_valid  input  NUM_INPUTS  per-input data valid, bit i belongs to input i.
REQ-010 in_ready  output  NUM_INPUTS  per-input data consumed this cycle.
REQ-011 in_data  input  NUM_INPUTS*WIDTH  packed data, input i at bits [i*WIDTH +: WIDTH].
REQ-012 out_valid  output  1  output buffer head valid.
REQ-013 out_ready  input  1  downstream accepts the head.
REQ-014 out_data  output  WIDTH  output buffer head data.
REQ-015 sel_err  output  1  sticky flag set when an out-of-range select token has been consumed.

Function
REQ-016 The block SHALL contain a 2-entry FIFO output buffer with occupancy count 0..2.
REQ-017 space = (count < 2); the block SHALL ignore out_ready when computing space, so there is no combinational path from out_ready to any ready output.
REQ-018 Legal fire: sel_valid && sel_data < NUM_INPUTS && in_valid[sel_data] && space.
REQ-019 On a legal fire, the block SHALL assert sel_ready and in_ready[sel_data] in the same cycle and push in_data[sel_data] into the buffer.
REQ-020 in_ready[j] SHALL be 0 for every j != sel_data, and every in_ready bit SHALL be 0 when no legal fire occurs.
REQ-021 Illegal select (sel_valid && sel_data >= NUM_INPUTS): the block SHALL assert sel_ready regardless of space, keep all in_ready bits at 0, push nothing, and set sel_err.
REQ-022 Unselected inputs SHALL hold their tokens; in_valid on an unselected input SHALL have no effect.
REQ-023 Latency: data pushed in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1 when the buffer was empty.
REQ-024 Pop occurs when out_valid && out_ready; out_data SHALL present the oldest entry (FIFO order).
REQ-025 A simultaneous push and pop SHALL leave count unchanged and preserve order; at count=1 this sustains one token per cycle.
REQ-026 At count=2 with out_ready=1, the pop SHALL occur and no push SHALL occur that cycle; a push becomes possible the following cycle.
REQ-027 out_valid SHALL equal (count != 0) and SHALL be driven from a register only.
REQ-028 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 Read and write pointers SHALL be 1 bit each and wrap 1->0.
REQ-030 sel_ready and in_ready SHALL be combinational functions of sel_valid, sel_data, in_valid and registered count only.

Reset
REQ-031 Asserting rst_n low SHALL immediately clear count, both pointers and sel_err, and force out_valid=0, independent of clk.
REQ-032 During reset, sel_ready and in_ready SHALL be 0, and out_data SHALL be 0.
REQ-033 Buffered tokens present when reset asserts SHALL be discarded; on the first edge after deassertion the block SHALL behave as though empty.
REQ-034 sel_err SHALL clear only on reset.

Verification
REQ-035 Basic route: NUM_INPUTS=4, sel=2, in_data[2]=0xA5A5_0001, all in_valid=1, out_ready=1 -> in_ready=4'b0100 in cycle 0, out_data=0xA5A5_0001 with out_valid=1 in cycle 1, and inputs 0, 1 and 3 are not consumed.
REQ-036 Streaming: 8 tokens with sel alternating 0/1, out_ready=1 constantly -> one output per cycle after 1-cycle latency, order preserved, no bubbles.
REQ-037 Backpressure: out_ready=0, offer 3 tokens (0x11, 0x22, 0x33) -> first two accepted, sel_ready=0 on the third, out_data held at 0x11; after out_ready rises, outputs are 0x11, 0x22, 0x33 in order.
REQ-038 Waiting input: sel_valid=1, sel=1, in_valid[1]=0 for 5 cycles -> sel_ready=0 throughout; in_valid[1] rises -> fire in that cycle.
REQ-039 Illegal select: NUM_INPUTS=3, sel=3 -> sel_ready=1, in_ready=0, nothing pushed, and sel_err=1 from the next cycle until reset.
REQ-040 Mid-operation reset: buffer at count=2, rst_n pulsed low between edges -> out_valid=0 immediately; after release, a new token emerges alone with 1-cycle latency.

Source files
------------

// File: rtl/handshake_mux.sv
// Select-token driven N:1 handshake multiplexer feeding a 2-entry output FIFO.
// A token on sel picks which data input is forwarded; out-of-range tokens are consumed and flagged.
module handshake_mux #(
    parameter  int WIDTH      = 32,
    parameter  int NUM_INPUTS = 2,
    localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sel_valid,
    output logic                          sel_ready,
    input  logic [SEL_WIDTH-1:0]          sel_data,
    input  logic [NUM_INPUTS-1:0]         in_valid,
    output logic [NUM_INPUTS-1:0]         in_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          sel_err
);

    logic [1:0]            count_reg;
    logic [1:0]            count_next;
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic                  out_valid_reg;
    logic                  sel_err_reg;
    logic [WIDTH-1:0]      mem_reg [2];

    logic [NUM_INPUTS-1:0] sel_hit;
    logic                  in_range;
    logic                  sel_avail;
    logic                  space;
    logic                  fire;
    logic                  illegal;
    logic                  pop;
    logic [WIDTH-1:0]      push_data;

    // One-hot decode of the select token; an all-zero result means out of range.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_decode
            assign sel_hit[gi] = (sel_data == SEL_WIDTH'(gi));
        end
    endgenerate

    assign in_range  = |sel_hit;
    assign sel_avail = |(sel_hit & in_valid);
    // Space deliberately ignores out_ready so no ready output depends on it.
    assign space     = (count_reg != 2'd2);
    assign fire      = rst_n & sel_valid & sel_avail & space;
    assign illegal   = rst_n & sel_valid & ~in_range;
    assign pop       = out_valid_reg & out_ready;

    assign sel_ready = fire | illegal;
    assign in_ready  = fire ? sel_hit : '0;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_hit[i]) begin
                push_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        count_next = count_reg + {1'b0, fire} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= 2'd0;
            rd_ptr_reg    <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            sel_err_reg   <= 1'b0;
        end else begin
            count_reg     <= count_next;
            out_valid_reg <= (count_next != 2'd0);
            if (fire) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (illegal) begin
                sel_err_reg <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the head is masked to zero whenever it is not valid.
    always_ff @(posedge clk) begin
        if (fire) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_valid_reg ? mem_reg[rd_ptr_reg] : '0;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_handshake_mux.sv
// Directed bench for handshake_mux: a 4-input instance for routing/flow tests
// and a 3-input instance for the out-of-range select case.
module tb_handshake_mux;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          sel_valid;
    logic          sel_ready;
    logic [1:0]    sel_data;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          sel_err;

    logic          sel_valid3;
    logic          sel_ready3;
    logic [1:0]    sel_data3;
    logic [2:0]    in_valid3;
    logic [2:0]    in_ready3;
    logic [95:0]   in_data3;
    logic          out_valid3;
    logic          out_ready3;
    logic [W-1:0]  out_data3;
    logic          sel_err3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    handshake_mux #(.WIDTH(W), .NUM_INPUTS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_data(sel_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel_err(sel_err)
    );

    handshake_mux #(.WIDTH(W), .NUM_INPUTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .sel_valid(sel_valid3), .sel_ready(sel_ready3), .sel_data(sel_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .sel_err(sel_err3)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #3;
    endtask

    task automatic set_in(input int idx, input logic [W-1:0] val);
        in_data[idx*W +: W] = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        sel_valid  = 1'b1;
        sel_data   = 2'd1;
        in_valid   = 4'hF;
        in_data    = '0;
        out_ready  = 1'b1;
        sel_valid3 = 1'b0;
        sel_data3  = 2'd0;
        in_valid3  = 3'b111;
        in_data3   = '0;
        out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) set_in(i, 32'h1000_0000 + i);

        // Reset state, with a would-be legal request present.
        #3;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data",  64'(out_data),  64'd0);
        check_val("rst_sel_ready", 64'(sel_ready), 64'd0);
        check_val("rst_in_ready",  64'(in_ready),  64'd0);
        check_val("rst_sel_err",   64'(sel_err),   64'd0);
        sel_valid = 1'b0;
        #9;
        rst_n = 1'b1;

        // Basic route through input 2.
        next_cycle();
        set_in(2, 32'hA5A5_0001);
        sel_data  = 2'd2;
        sel_valid = 1'b1;
        settle();
        check_val("route_sel_ready", 64'(sel_ready), 64'd1);
        check_val("route_in_ready",  64'(in_ready),  64'b0100);
        check_val("route_c0_valid",  64'(out_valid), 64'd0);
        next_cycle();
        sel_valid = 1'b0;
        settle();
        check_val("route_c1_valid",  64'(out_valid), 64'd1);
        check_val("route_c1_data",   64'(out_data),  64'hA5A5_0001);
        check_val("route_c1_ready",  64'(in_ready),  64'd0);
        next_cycle();
        settle();
        check_val("route_c2_valid",  64'(out_valid), 64'd0);

        // Streaming: 8 tokens alternating inputs 0/1, no bubbles.
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            sel_valid = 1'b1;
            sel_data  = 2'(k % 2);
            set_in(k % 2, 32'h100 + k);
            settle();
            check_val($sformatf("stream%0d_sel_ready", k), 64'(sel_ready), 64'd1);
            check_val($sformatf("stream%0d_in_ready", k),  64'(in_ready),  64'(4'b0001 << (k % 2)));
            if (k > 0) begin
                check_val($sformatf("stream%0d_out_valid", k), 64'(out_valid), 64'd1);
                check_val($sformatf("stream%0d_out_data", k),  64'(out_data),  64'(32'h100 + k - 1));
            end
        end
        next_cycle();
        sel_valid = 1'b0;
        settle();
        check_val("stream_last_valid", 64'(out_valid), 64'd1);
        check_val("stream_last_data",  64'(out_data),  64'h107);
        next_cycle();
        settle();
        check_val("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure: third token refused while two are held.
        out_ready = 1'b0;
        sel_data  = 2'd0;
        next_cycle();
        sel_valid = 1'b1;
        set_in(0, 32'h11);
        settle();
        check_val("bp_t1_sel_ready", 64'(sel_ready), 64'd1);
        next_cycle();
        set_in(0, 32'h22);
        settle();
        check_val("bp_t2_sel_ready", 64'(sel_ready), 64'd1);
        check_val("bp_t2_out_data",  64'(out_data),  64'h11);
        next_cycle();
        set_in(0, 32'h33);
        settle();
        check_val("bp_t3_sel_ready", 64'(sel_ready), 64'd0);
        check_val("bp_t3_in_ready",  64'(in_ready),  64'd0);
        check_val("bp_hold_data",    64'(out_data),  64'h11);
        next_cycle();
        settle();
        check_val("bp_hold2_data",   64'(out_data),  64'h11);
        check_val("bp_hold2_ready",  64'(sel_ready), 64'd0);
        next_cycle();
        out_ready = 1'b1;
        settle();
        check_val("bp_full_pop_ready", 64'(sel_ready), 64'd0);
        check_val("bp_out0",           64'(out_data),  64'h11);
        next_cycle();
        settle();
        check_val("bp_t3_accept",      64'(sel_ready), 64'd1);
        check_val("bp_out1",           64'(out_data),  64'h22);
        next_cycle();
        sel_valid = 1'b0;
        settle();
        check_val("bp_out2",           64'(out_data),  64'h33);
        check_val("bp_out2_valid",     64'(out_valid), 64'd1);
        next_cycle();
        settle();
        check_val("bp_drained",        64'(out_valid), 64'd0);

        // Waiting input: select 1 held while input 1 is not valid.
        next_cycle();
        sel_valid = 1'b1;
        sel_data  = 2'd1;
        in_valid  = 4'b1101;
        set_in(1, 32'h77);
        for (int k = 0; k < 5; k++) begin
            settle();
            check_val($sformatf("wait%0d_sel_ready", k), 64'(sel_ready), 64'd0);
            check_val($sformatf("wait%0d_in_ready", k),  64'(in_ready),  64'd0);
            next_cycle();
        end
        in_valid = 4'b1111;
        settle();
        check_val("wait_fire_sel_ready", 64'(sel_ready), 64'd1);
        check_val("wait_fire_in_ready",  64'(in_ready),  64'b0010);
        next_cycle();
        sel_valid = 1'b0;
        settle();
        check_val("wait_out_data",  64'(out_data),  64'h77);
        check_val("wait_out_valid", 64'(out_valid), 64'd1);

        // Illegal select on the 3-input instance.
        next_cycle();
        in_data3   = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        sel_valid3 = 1'b1;
        sel_data3  = 2'd3;
        settle();
        check_val("ill_sel_err_before", 64'(sel_err3),   64'd0);
        check_val("ill_sel_ready",      64'(sel_ready3), 64'd1);
        check_val("ill_in_ready",       64'(in_ready3),  64'd0);
        next_cycle();
        sel_valid3 = 1'b0;
        settle();
        check_val("ill_sel_err",        64'(sel_err3),   64'd1);
        check_val("ill_nothing_pushed", 64'(out_valid3), 64'd0);
        next_cycle();
        sel_valid3 = 1'b1;
        sel_data3  = 2'd2;
        settle();
        check_val("ill_legal_in_ready", 64'(in_ready3),  64'b100);
        next_cycle();
        sel_valid3 = 1'b0;
        settle();
        check_val("ill_legal_data",     64'(out_data3),  64'h3333_0002);
        check_val("ill_sel_err_sticky", 64'(sel_err3),   64'd1);

        // Mid-operation reset with a full buffer.
        out_ready = 1'b0;
        next_cycle();
        sel_valid = 1'b1;
        sel_data  = 2'd0;
        set_in(0, 32'hAA);
        next_cycle();
        set_in(0, 32'hBB);
        next_cycle();
        settle();
        check_val("mid_full_ready", 64'(sel_ready), 64'd0);
        check_val("mid_full_valid", 64'(out_valid), 64'd1);
        next_cycle();
        rst_n = 1'b0;
        #2;
        check_val("mid_rst_valid",     64'(out_valid), 64'd0);
        check_val("mid_rst_data",      64'(out_data),  64'd0);
        check_val("mid_rst_sel_ready", 64'(sel_ready), 64'd0);
        check_val("mid_rst_sel_err",   64'(sel_err3),  64'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sel_data  = 2'd3;
        set_in(3, 32'hCC);
        #1;
        check_val("mid_post_in_ready", 64'(in_ready),  64'b1000);
        check_val("mid_post_valid",    64'(out_valid), 64'd0);
        next_cycle();
        sel_valid = 1'b0;
        settle();
        check_val("mid_new_valid", 64'(out_valid), 64'd1);
        check_val("mid_new_data",  64'(out_data),  64'hCC);
        next_cycle();
        settle();
        check_val("mid_alone", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
